// File: rtl/vblank_ram_scheduler.sv
// RAM port B sequencer: per-frame flag write plus game-state block fetch into an
// atomically published shadow bank, with single-word auxiliary access between frames.
module vblank_ram_scheduler #(
  parameter logic [15:0] POS_BASE   = 16'h0100,
  parameter int unsigned NUM_WORDS  = 4,
  parameter logic [15:0] FLAG_ADDR  = 16'hFFFE,
  parameter logic [15:0] FLAG_VALUE = 16'h0001
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    vblank_start,
  input  logic [15:0]             ram_q_b,
  output logic [15:0]             ram_addr_b,
  output logic [15:0]             ram_data_b,
  output logic                    ram_we_b,
  input  logic                    aux_req,
  input  logic                    aux_we,
  input  logic [15:0]             aux_addr,
  input  logic [15:0]             aux_wdata,
  output logic                    aux_gnt,
  output logic                    aux_rvalid,
  output logic [15:0]             aux_rdata,
  output logic [16*NUM_WORDS-1:0] state_words,
  output logic                    frame_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_ISS,
    S_CAP,
    S_AUX_WR,
    S_AUX_ISS,
    S_AUX_CAP
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [3:0]              idx;
  logic                    pend;
  logic                    load_go;
  logic                    last_word;
  logic [16*NUM_WORDS-1:0] shadow;
  logic [16*NUM_WORDS-1:0] shadow_nx;

  assign load_go   = vblank_start | pend;
  assign last_word = (idx == LAST_IDX);

  always_ff @(posedge sys_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (load_go)      state_nx = S_FLAG;
        else if (aux_req) state_nx = aux_we ? S_AUX_WR : S_AUX_ISS;
      end
      S_FLAG:    state_nx = S_ISS;
      S_ISS:     state_nx = S_CAP;
      S_CAP:     state_nx = last_word ? S_IDLE : S_ISS;
      S_AUX_WR:  state_nx = S_IDLE;
      S_AUX_ISS: state_nx = S_AUX_CAP;
      S_AUX_CAP: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Shadow bank with the word arriving this edge merged in, so the final
  // publish includes it without an extra cycle.
  always_comb begin
    shadow_nx = shadow;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (idx == i[3:0]) shadow_nx[16*i +: 16] = ram_q_b;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ram_addr_b  <= POS_BASE;
      ram_data_b  <= '0;
      ram_we_b    <= 1'b0;
      aux_gnt     <= 1'b0;
      aux_rvalid  <= 1'b0;
      aux_rdata   <= '0;
      state_words <= '0;
      shadow      <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      idx         <= '0;
      pend        <= 1'b0;
    end else begin
      aux_gnt     <= 1'b0;
      aux_rvalid  <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_go) begin
            ram_addr_b <= FLAG_ADDR;
            ram_data_b <= FLAG_VALUE;
            ram_we_b   <= 1'b1;
            idx        <= '0;
            pend       <= 1'b0;
          end else if (aux_req) begin
            ram_addr_b <= aux_addr;
            ram_data_b <= aux_wdata;
            ram_we_b   <= aux_we;
            aux_gnt    <= 1'b1;
          end
        end
        S_FLAG: begin
          ram_we_b   <= 1'b0;
          ram_addr_b <= POS_BASE;
          if (vblank_start) overrun <= 1'b1;
        end
        S_ISS: begin
          if (vblank_start) overrun <= 1'b1;
        end
        S_CAP: begin
          shadow <= shadow_nx;
          if (vblank_start) overrun <= 1'b1;
          if (last_word) begin
            state_words <= shadow_nx;
            frame_valid <= 1'b1;
          end else begin
            idx        <= idx + 4'd1;
            ram_addr_b <= POS_BASE + 16'(idx) + 16'd1;
          end
        end
        S_AUX_WR: begin
          ram_we_b <= 1'b0;
          if (vblank_start) pend <= 1'b1;
        end
        S_AUX_ISS: begin
          if (vblank_start) pend <= 1'b1;
        end
        S_AUX_CAP: begin
          aux_rdata  <= ram_q_b;
          aux_rvalid <= 1'b1;
          if (vblank_start) pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_ram_scheduler.sv
// Directed bench for vblank_ram_scheduler: two instances (default map and a
// wrapping POS_BASE) each backed by a one-cycle-latency synchronous RAM model.
module tb_vblank_ram_scheduler;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        reset = 1'b1;
  logic        vblank_start = 1'b0;
  logic        aux_req = 1'b0;
  logic        aux_we = 1'b0;
  logic [15:0] aux_addr = '0;
  logic [15:0] aux_wdata = '0;
  logic [15:0] ram_q_b;
  logic [15:0] ram_addr_b, ram_data_b, aux_rdata;
  logic        ram_we_b, aux_gnt, aux_rvalid, frame_valid, busy, overrun;
  logic [63:0] state_words;

  logic        vblank2 = 1'b0;
  logic        aux_req2 = 1'b0;
  logic        aux_we2 = 1'b0;
  logic [15:0] aux_addr2 = '0;
  logic [15:0] aux_wdata2 = '0;
  logic [15:0] ram_q_b2;
  logic [15:0] ram_addr_b2, ram_data_b2, aux_rdata2;
  logic        ram_we_b2, aux_gnt2, aux_rvalid2, frame_valid2, busy2, overrun2;
  logic [63:0] state_words2;

  vblank_ram_scheduler dut (
    .sys_clk(sys_clk), .reset(reset), .vblank_start(vblank_start),
    .ram_q_b(ram_q_b), .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b),
    .ram_we_b(ram_we_b), .aux_req(aux_req), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_gnt(aux_gnt),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata), .state_words(state_words),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
  );

  vblank_ram_scheduler #(
    .POS_BASE(16'hFFFE), .NUM_WORDS(4), .FLAG_ADDR(16'h0800), .FLAG_VALUE(16'h0001)
  ) dut2 (
    .sys_clk(sys_clk), .reset(reset), .vblank_start(vblank2),
    .ram_q_b(ram_q_b2), .ram_addr_b(ram_addr_b2), .ram_data_b(ram_data_b2),
    .ram_we_b(ram_we_b2), .aux_req(aux_req2), .aux_we(aux_we2),
    .aux_addr(aux_addr2), .aux_wdata(aux_wdata2), .aux_gnt(aux_gnt2),
    .aux_rvalid(aux_rvalid2), .aux_rdata(aux_rdata2), .state_words(state_words2),
    .frame_valid(frame_valid2), .busy(busy2), .overrun(overrun2)
  );

  // RAM models: registered read data, so address driven at edge N is read at N+1
  // and visible to the DUT at N+2. A bench-side port preloads contents.
  logic [15:0] mem1 [65536];
  logic [15:0] mem2 [65536];
  logic        pk_en = 1'b0;
  logic        pk_sel = 1'b0;
  logic [15:0] pk_addr = '0;
  logic [15:0] pk_data = '0;

  always @(posedge sys_clk) begin
    if (pk_en && !pk_sel)  mem1[pk_addr] <= pk_data;
    else if (ram_we_b)     mem1[ram_addr_b] <= ram_data_b;
    if (pk_en && pk_sel)   mem2[pk_addr] <= pk_data;
    else if (ram_we_b2)    mem2[ram_addr_b2] <= ram_data_b2;
    ram_q_b  <= mem1[ram_addr_b];
    ram_q_b2 <= mem2[ram_addr_b2];
  end

  // Event counters over previous-cycle values of dut outputs.
  int we_cnt = 0, fv_cnt = 0, ovr_cnt = 0, gnt_cnt = 0, rv_cnt = 0, busy_cnt = 0;
  always @(posedge sys_clk) begin
    if (ram_we_b)    we_cnt++;
    if (frame_valid) fv_cnt++;
    if (overrun)     ovr_cnt++;
    if (aux_gnt)     gnt_cnt++;
    if (aux_rvalid)  rv_cnt++;
    if (busy)        busy_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic poke(input logic sel, input logic [15:0] a, input logic [15:0] d);
    pk_sel = sel; pk_addr = a; pk_data = d; pk_en = 1'b1;
    cyc();
    pk_en = 1'b0;
  endtask

  task automatic wait_fv(input logic sel, output int n);
    n = 0;
    while (!(sel ? frame_valid2 : frame_valid) && n < 40) begin
      cyc();
      n++;
    end
  endtask

  int n;
  int we0, fv0, ovr0, gnt0, rv0, busy0;

  task automatic snap();
    we0 = we_cnt; fv0 = fv_cnt; ovr0 = ovr_cnt;
    gnt0 = gnt_cnt; rv0 = rv_cnt; busy0 = busy_cnt;
  endtask

  initial begin
    cyc(3);
    check("rst_addr",  64'(ram_addr_b), 64'h0100);
    check("rst_data",  64'(ram_data_b), 64'h0);
    check("rst_pulses", 64'({ram_we_b, aux_gnt, aux_rvalid, frame_valid, overrun, busy}), 64'h0);
    check("rst_rdata", 64'(aux_rdata), 64'h0);
    check("rst_sw",    state_words, 64'h0);
    check("rst_addr2", 64'(ram_addr_b2), 64'hFFFE);
    poke(1'b0, 16'h0100, 16'h0011);
    poke(1'b0, 16'h0101, 16'h0022);
    poke(1'b0, 16'h0102, 16'h0033);
    poke(1'b0, 16'h0103, 16'h0044);
    poke(1'b0, 16'h0200, 16'hBEEF);
    reset = 1'b0;
    cyc(2);

    // Basic frame load
    snap();
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
    check("t1_flag_we",   64'(ram_we_b), 64'h1);
    check("t1_flag_addr", 64'(ram_addr_b), 64'hFFFE);
    check("t1_flag_data", 64'(ram_data_b), 64'h0001);
    wait_fv(1'b0, n);
    check("t1_fv_lat", 64'(n), 64'd9);
    check("t1_sw", state_words, 64'h0044_0033_0022_0011);
    check("t1_busy_end", 64'(busy), 64'h0);
    cyc(4);
    check("t1_flag_mem", 64'(mem1[16'hFFFE]), 64'h0001);
    check("t1_we_cnt",   64'(we_cnt - we0), 64'd1);
    check("t1_fv_cnt",   64'(fv_cnt - fv0), 64'd1);
    check("t1_busy_cnt", 64'(busy_cnt - busy0), 64'd9);

    // Auxiliary read
    snap();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0200;
    n = 0;
    do begin cyc(); n++; end while (!aux_gnt && n < 20);
    aux_req = 1'b0;
    check("t2_gnt_lat", 64'(n), 64'd1);
    check("t2_busy", 64'(busy), 64'h1);
    cyc();
    check("t2_rv_early", 64'(aux_rvalid), 64'h0);
    cyc();
    check("t2_rvalid", 64'(aux_rvalid), 64'h1);
    check("t2_rdata",  64'(aux_rdata), 64'hBEEF);
    cyc(3);
    check("t2_gnt_cnt",  64'(gnt_cnt - gnt0), 64'd1);
    check("t2_busy_cnt", 64'(busy_cnt - busy0), 64'd2);
    check("t2_rdata_hold", 64'(aux_rdata), 64'hBEEF);

    // Auxiliary write with vblank in the grant cycle
    poke(1'b0, 16'h0100, 16'h1111);
    poke(1'b0, 16'h0101, 16'h2222);
    poke(1'b0, 16'h0102, 16'h3333);
    poke(1'b0, 16'h0103, 16'h4444);
    snap();
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0300; aux_wdata = 16'h1234;
    cyc();
    check("t3_gnt", 64'({aux_gnt, ram_we_b}), 64'h3);
    aux_req = 1'b0;
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
    check("t3_idle", 64'({busy, ram_we_b}), 64'h0);
    check("t3_wmem", 64'(mem1[16'h0300]), 64'h1234);
    cyc();
    check("t3_pend_flag", 64'({ram_we_b, ram_addr_b}), {47'h0, 1'b1, 16'hFFFE});
    wait_fv(1'b0, n);
    check("t3_fv_lat", 64'(n), 64'd9);
    check("t3_sw", state_words, 64'h4444_3333_2222_1111);
    cyc(3);
    check("t3_ovr_cnt", 64'(ovr_cnt - ovr0), 64'd0);
    check("t3_we_cnt",  64'(we_cnt - we0), 64'd2);

    // vblank and aux_req together: load wins, aux granted right after
    poke(1'b0, 16'h0100, 16'h5001);
    poke(1'b0, 16'h0101, 16'h5002);
    poke(1'b0, 16'h0102, 16'h5003);
    poke(1'b0, 16'h0103, 16'h5004);
    snap();
    vblank_start = 1'b1;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0200;
    cyc();
    vblank_start = 1'b0;
    check("t4_load_first", 64'({aux_gnt, ram_we_b, ram_addr_b}), {46'h0, 2'b01, 16'hFFFE});
    wait_fv(1'b0, n);
    check("t4_fv_lat", 64'(n), 64'd9);
    check("t4_sw", state_words, 64'h5004_5003_5002_5001);
    check("t4_no_gnt", 64'(gnt_cnt - gnt0), 64'd0);
    cyc();
    check("t4_gnt_after", 64'(aux_gnt), 64'h1);
    aux_req = 1'b0;
    cyc(2);
    check("t4_rvalid", 64'({aux_rvalid, aux_rdata}), {47'h0, 1'b1, 16'hBEEF});

    // Second vblank at E4: overrun, single frame, no extra flag write
    cyc(2);
    snap();
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
    cyc(3);
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
    check("t5_overrun", 64'(overrun), 64'h1);
    wait_fv(1'b0, n);
    check("t5_fv_lat", 64'(n), 64'd5);
    cyc(12);
    check("t5_fv_cnt",  64'(fv_cnt - fv0), 64'd1);
    check("t5_we_cnt",  64'(we_cnt - we0), 64'd1);
    check("t5_ovr_cnt", 64'(ovr_cnt - ovr0), 64'd1);
    check("t5_idle",    64'(busy), 64'h0);

    // Wrapping POS_BASE on the second instance
    poke(1'b1, 16'hFFFE, 16'hA001);
    poke(1'b1, 16'hFFFF, 16'hA002);
    poke(1'b1, 16'h0000, 16'hA003);
    poke(1'b1, 16'h0001, 16'hA004);
    vblank2 = 1'b1;
    cyc();
    vblank2 = 1'b0;
    check("t6_flag_addr", 64'(ram_addr_b2), 64'h0800);
    wait_fv(1'b1, n);
    check("t6_fv_lat", 64'(n), 64'd9);
    check("t6_sw", state_words2, 64'hA004_A003_A002_A001);
    check("t6_flag_mem", 64'(mem2[16'h0800]), 64'h0001);

    // Reset at E5 of a load
    cyc(2);
    snap();
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
    cyc(4);
    reset = 1'b1;
    cyc();
    check("t7_addr", 64'(ram_addr_b), 64'h0100);
    check("t7_data", 64'(ram_data_b), 64'h0);
    check("t7_flags", 64'({ram_we_b, busy, frame_valid, overrun}), 64'h0);
    check("t7_sw", state_words, 64'h0);
    reset = 1'b0;
    cyc(12);
    check("t7_no_fv", 64'(fv_cnt - fv0), 64'd0);
    check("t7_busy", 64'(busy), 64'h0);

    // Reset during an aux read: no rvalid for the aborted access
    snap();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0200;
    cyc();
    aux_req = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(5);
    check("t8_no_rv", 64'(rv_cnt - rv0), 64'd0);
    check("t8_rdata", 64'(aux_rdata), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vblank_ram_scheduler.md
# vblank_ram_scheduler

Sequencer and arbiter for RAM port B on the display side. Once per frame, on the vblank start pulse, it writes the vblank flag word and then reads a block of game-state words (player Y, obstacle X, and so on) into a shadow register bank. The bank is published atomically to the sprite generators. Between frame loads it grants single-word read/write access on the same port to one auxiliary requester (debug/DMA).

## Interface
Parameters:
- POS_BASE, 16'h0100, address of the first game-state word.
- NUM_WORDS, 4, number of consecutive words fetched per frame (legal range 1..16).
- FLAG_ADDR, 16'hFFFE, address of the vblank flag word.
- FLAG_VALUE, 16'h0001, value written to FLAG_ADDR.

Ports:
- sys_clk  in  1  system clock (50 MHz); the only clock.
- reset  in  1  reset, synchronous and active-high.
- vblank_start  in  1  single-cycle pulse in the sys_clk domain (already synchronised and edge-detected upstream).
- ram_q_b  in  16  RAM port B read data.
- ram_addr_b  out  16  RAM port B address (registered).
- ram_data_b  out  16  RAM port B write data (registered).
- ram_we_b  out  1  RAM port B write enable (registered).
- aux_req  in  1  auxiliary access request; held high until aux_gnt is seen.
- aux_we  in  1  1 = write, 0 = read; stable while aux_req is high.
- aux_addr  in  16  auxiliary address; stable while aux_req is high.
- aux_wdata  in  16  auxiliary write data; stable while aux_req is high.
- aux_gnt  out  1  one-cycle pulse: the auxiliary request was issued.
- aux_rvalid  out  1  one-cycle pulse: aux_rdata is valid.
- aux_rdata  out  16  captured read data; held until the next auxiliary read.
- state_words  out  16*NUM_WORDS  published bank; word i is at bits [16i+15:16i].
- frame_valid  out  1  one-cycle pulse in the cycle state_words changes.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  one-cycle pulse: vblank_start arrived during a frame load and was dropped.

## Operation
- RAM read latency: the RAM samples ram_addr_b one edge after this block drives it. The block captures ram_q_b on the next edge, two edges after driving the address.
- States:
  - IDLE:
    - If vblank_start or pend is set: drive FLAG_ADDR, FLAG_VALUE and we=1; idx=0; clear pend; go to FLAG.
    - Else if aux_req: drive aux_addr, aux_wdata and we=aux_we; pulse aux_gnt; go to AUX_WR if aux_we, else AUX_ISS.
  - FLAG: we=0; addr=POS_BASE; go to ISS.
  - ISS: go to CAP.
  - CAP: shadow[idx]=ram_q_b.
    - If idx==NUM_WORDS-1: copy the shadow bank to state_words, including the word captured this edge; pulse frame_valid; go to IDLE.
    - Else: idx+1; addr=POS_BASE+idx+1; go to ISS.
  - AUX_WR: we=0; go to IDLE.
  - AUX_ISS: go to AUX_CAP.
  - AUX_CAP: aux_rdata=ram_q_b; pulse aux_rvalid; go to IDLE.
- Priority: a frame load beats an auxiliary request when both are present in IDLE.
- Pending vblank:
  - vblank_start during an AUX_* state sets pend. The frame load starts on the first IDLE cycle, ahead of aux_req.
  - vblank_start during FLAG/ISS/CAP: pulse overrun, do not set pend, and continue the current load.
- Address arithmetic is 16-bit modulo. POS_BASE+idx wraps from 16'hFFFF to 16'h0000 with no error.
- ram_addr_b and ram_data_b hold their last value when not being changed. ram_we_b is high only in the single cycle following a write issue.
- state_words never shows a partially loaded frame.

## Timing
- Reset values:
  - ram_addr_b=POS_BASE, ram_data_b=0, ram_we_b=0.
  - aux_gnt=aux_rvalid=frame_valid=overrun=0; busy=0.
  - aux_rdata=0, state_words=0.
  - State IDLE, idx=0, pend=0.
- Reset asserted mid-load or mid-aux access: return to IDLE with the reset values on the next edge. state_words keeps no partial data (it is cleared). No aux_rvalid is issued for an aborted read.
- Frame load, with vblank_start sampled at edge E0:
  - Flag write is visible (we=1) in cycle E0..E1.
  - Word i is captured at edge E(3+2i).
  - state_words updates and frame_valid is high after E(2*NUM_WORDS+1) (E9 for NUM_WORDS=4).
  - busy is high from E0 to that edge, i.e. 2*NUM_WORDS+1 cycles.
- Auxiliary write granted at E0: aux_gnt and we high for one cycle; busy for 1 cycle.
- Auxiliary read granted at E0: aux_rvalid and aux_rdata valid after E2; busy for 2 cycles.
- Back-to-back auxiliary accesses: the minimum gap from IDLE to the next grant is 0 cycles after returning to IDLE.

## Test plan
- Reset, then vblank_start with RAM[0x100..0x103]=0x0011,0x0022,0x0033,0x0044 -> RAM[0xFFFE]=0x0001. state_words={0x0044,0x0033,0x0022,0x0011} and frame_valid pulse exactly 9 edges after the pulse; ram_we_b high for exactly one cycle.
- aux_req read of 0x0200 (RAM=0xBEEF) while idle -> aux_gnt 1 cycle; aux_rvalid with aux_rdata=0xBEEF two edges after grant.
- aux_req write 0x0300<=0x1234, and vblank_start in the grant cycle -> write completes. The frame load starts the cycle after returning to IDLE; no overrun.
- vblank_start and aux_req in the same IDLE cycle -> frame load first, aux granted the cycle after frame_valid.
- Second vblank_start at E4 of a load -> overrun pulse; a single frame_valid; no extra flag write.
- POS_BASE=16'hFFFE, NUM_WORDS=4 -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001. Separately, assert reset at E5 of a load -> outputs return to reset values; no frame_valid.
